// File: rtl/logic_unit_acc_pkg.sv
// Shared types for the logic unit: operation codes, FSM states and the op-field width.
package logic_unit_pkg;

  localparam int OP_W = 3;

  typedef enum logic [OP_W-1:0] {
    OP_AND     = 3'd0,
    OP_OR      = 3'd1,
    OP_XOR     = 3'd2,
    OP_NAND    = 3'd3,
    OP_NOR     = 3'd4,
    OP_XNOR    = 3'd5,
    OP_ACC_AND = 3'd6,
    OP_ACC_OR  = 3'd7
  } logic_op_e;

  typedef enum logic {
    IDLE = 1'b0,
    ACC  = 1'b1
  } state_e;

  function automatic logic is_acc_op(input logic_op_e op);
    return (op == OP_ACC_AND) || (op == OP_ACC_OR);
  endfunction

endpackage

// File: rtl/logic_unit_acc_if.sv
// Operand/result handshake bundle for logic_unit_acc.
// Handshake: a transfer happens on a rising edge where valid && ready; the
// sender holds its payload stable while valid is high and ready is low.
interface logic_unit_acc_if
  import logic_unit_pkg::*;
#(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic             in_last;
  logic [OP_W-1:0]  op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] y;
  logic             y_zero;
  logic             y_ones;

  modport master (
    output in_valid, in_last, op, a, b, out_ready,
    input  in_ready, out_valid, y, y_zero, y_ones
  );

  modport slave (
    input  in_valid, in_last, op, a, b, out_ready,
    output in_ready, out_valid, y, y_zero, y_ones
  );
endinterface

// File: rtl/logic_unit_acc_op_core.sv
// Combinational bitwise function block; accumulate opcodes yield zero here.
module logic_op_core
  import logic_unit_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic_op_e        op_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic [WIDTH-1:0] y_o
);

  always_comb begin
    y_o = '0;
    case (op_i)
      OP_AND:  y_o = a_i & b_i;
      OP_OR:   y_o = a_i | b_i;
      OP_XOR:  y_o = a_i ^ b_i;
      OP_NAND: y_o = ~(a_i & b_i);
      OP_NOR:  y_o = ~(a_i | b_i);
      OP_XNOR: y_o = ~(a_i ^ b_i);
      default: y_o = '0;
    endcase
  end

endmodule

// File: rtl/logic_unit_acc.sv
// Registered bitwise logic unit with AND/OR burst accumulation.
// Optional result counter enabled by defining LOGIC_UNIT_STATS_EN.
module logic_unit_acc
  import logic_unit_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  logic_unit_acc_if.slave    bus,
`ifdef LOGIC_UNIT_STATS_EN
  output logic [15:0]        op_count,
`endif
  output state_e             state_o
);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic_op_e        acc_op_q, acc_op_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] y_q, y_d;
  logic             y_zero_q, y_ones_q;

  logic_op_e        op_in;
  logic             in_ready;
  logic             accept;
  logic             wr_en;
  logic [WIDTH-1:0] wr_val;
  logic [WIDTH-1:0] core_y;
  logic [WIDTH-1:0] acc_comb;

  assign op_in  = logic_op_e'(bus.op);
  assign accept = bus.in_valid && in_ready;

  logic_op_core #(.WIDTH(WIDTH)) u_core (
    .op_i (op_in),
    .a_i  (bus.a),
    .b_i  (bus.b),
    .y_o  (core_y)
  );

  // Once a burst is open only the latched op matters.
  assign acc_comb = (acc_op_q == OP_ACC_AND) ? (acc_q & bus.a) : (acc_q | bus.a);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      acc_q       <= '0;
      acc_op_q    <= OP_ACC_AND;
      out_valid_q <= 1'b0;
      y_q         <= '0;
      y_zero_q    <= 1'b1;
      y_ones_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      acc_op_q    <= acc_op_d;
      out_valid_q <= out_valid_d;
      y_q         <= y_d;
      y_zero_q    <= (y_d == '0);
      y_ones_q    <= (y_d == {WIDTH{1'b1}});
    end
  end

  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    acc_op_d = acc_op_q;
    wr_en    = 1'b0;
    wr_val   = '0;
    if (accept) begin
      case (state_q)
        IDLE: begin
          if (!is_acc_op(op_in)) begin
            wr_en  = 1'b1;
            wr_val = core_y;
          end else if (bus.in_last) begin
            wr_en  = 1'b1;
            wr_val = bus.a;
          end else begin
            acc_d    = bus.a;
            acc_op_d = op_in;
            state_d  = ACC;
          end
        end
        ACC: begin
          acc_d = acc_comb;
          if (bus.in_last) begin
            wr_en   = 1'b1;
            wr_val  = acc_comb;
            state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // A fresh result overrides the delivery of the previous one in the same cycle.
  always_comb begin
    in_ready    = !out_valid_q || bus.out_ready;
    out_valid_d = wr_en || (out_valid_q && !bus.out_ready);
    y_d         = wr_en ? wr_val : y_q;
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid_q;
  assign bus.y         = y_q;
  assign bus.y_zero    = y_zero_q;
  assign bus.y_ones    = y_ones_q;
  assign state_o       = state_q;

`ifdef LOGIC_UNIT_STATS_EN
  logic [15:0] op_count_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_count_q <= '0;
    end else if (wr_en && (op_count_q != 16'hFFFF)) begin
      op_count_q <= op_count_q + 16'd1;
    end
  end

  assign op_count = op_count_q;
`endif

endmodule

// File: tb/tb_logic_unit_acc.sv
// Bench for logic_unit_acc: directed vector table, corner sequences and a
// randomized run scored against a burst-level reference model.
module tb_logic_unit_acc;
  import logic_unit_pkg::*;

  localparam int W = 8;

  // clock / reset
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic_unit_acc_if #(.WIDTH(W)) bus();
  state_e dbg_state;
`ifdef LOGIC_UNIT_STATS_EN
  logic [15:0] op_count;
`endif

  logic_unit_acc #(.WIDTH(W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus      (bus),
`ifdef LOGIC_UNIT_STATS_EN
    .op_count (op_count),
`endif
    .state_o  (dbg_state)
  );

  int tests = 0;
  int fails = 0;

  logic dir_or = 1'b1;
  logic rnd_or = 1'b1;
  bit   rnd_ready = 1'b0;
  bit   sb_en = 1'b0;
  assign bus.out_ready = rnd_ready ? rnd_or : dir_or;

  logic [W-1:0]    exp_q[$];
  logic [W-1:0]    burst_q[$];
  logic [OP_W-1:0] burst_op;

  typedef struct {
    logic [OP_W-1:0] op;
    logic [W-1:0]    a;
    logic [W-1:0]    b;
    logic            last;
    logic            exp_v;
    logic [W-1:0]    exp_y;
    logic            exp_z;
    logic            exp_o;
  } vec_t;

  vec_t tbl[11];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [W-1:0] ref_bitwise(input int op, input logic [W-1:0] a, input logic [W-1:0] b);
    case (op)
      0: return a & b;
      1: return a | b;
      2: return a ^ b;
      3: return ~(a & b);
      4: return ~(a | b);
      default: return ~(a ^ b);
    endcase
  endfunction

  // reference model: collect a burst's operands, reduce them when the last one arrives
  task automatic model_beat(input int op, input logic [W-1:0] a, input logic [W-1:0] b, input logic last);
    logic [W-1:0] r;
    if (burst_q.size() == 0 && op < 6) begin
      exp_q.push_back(ref_bitwise(op, a, b));
    end else begin
      if (burst_q.size() == 0) burst_op = OP_W'(op);
      burst_q.push_back(a);
      if (last) begin
        r = burst_q[0];
        foreach (burst_q[i]) r = (burst_op == 3'd6) ? (r & burst_q[i]) : (r | burst_q[i]);
        exp_q.push_back(r);
        burst_q.delete();
      end
    end
  endtask

  // driver: called just after a rising edge; returns just after the accepting edge
  task automatic send(input int op, input logic [W-1:0] a, input logic [W-1:0] b, input logic last);
    bus.op = OP_W'(op);
    bus.a = a;
    bus.b = b;
    bus.in_last = last;
    bus.in_valid = 1'b1;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      if (bus.in_ready) begin
        if (sb_en) model_beat(op, a, b, last);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        return;
      end
      @(posedge clk);
      #1;
    end
    check("accept_timeout", 32'd0, 32'd1);
    bus.in_valid = 1'b0;
  endtask

  // random backpressure
  always @(posedge clk) begin
    if (rnd_ready) begin
      #1;
      rnd_or = ($urandom_range(0, 3) != 0);
    end
  end

  // scoreboard
  always @(negedge clk) begin
    logic [W-1:0] e;
    if (sb_en && bus.out_valid && bus.out_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_result", 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        check("rand_y", 32'(bus.y), 32'(e));
        check("rand_y_zero", 32'(bus.y_zero), 32'(e == '0));
        check("rand_y_ones", 32'(bus.y_ones), 32'(e == {W{1'b1}}));
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got running expected done");
    $fatal(1);
  end

  initial begin
    bus.in_valid = 1'b0;
    bus.in_last = 1'b0;
    bus.op = '0;
    bus.a = '0;
    bus.b = '0;

    tbl[0]  = '{3'd0, 8'hF0, 8'h3C, 1'b0, 1'b1, 8'h30, 1'b0, 1'b0};
    tbl[1]  = '{3'd1, 8'hF0, 8'h3C, 1'b0, 1'b1, 8'hFC, 1'b0, 1'b0};
    tbl[2]  = '{3'd2, 8'hF0, 8'h3C, 1'b0, 1'b1, 8'hCC, 1'b0, 1'b0};
    tbl[3]  = '{3'd3, 8'hF0, 8'h3C, 1'b0, 1'b1, 8'hCF, 1'b0, 1'b0};
    tbl[4]  = '{3'd4, 8'hF0, 8'h3C, 1'b0, 1'b1, 8'h03, 1'b0, 1'b0};
    tbl[5]  = '{3'd5, 8'hF0, 8'h3C, 1'b0, 1'b1, 8'h33, 1'b0, 1'b0};
    tbl[6]  = '{3'd6, 8'hFF, 8'h00, 1'b0, 1'b0, 8'h33, 1'b0, 1'b0};
    tbl[7]  = '{3'd6, 8'h7E, 8'h00, 1'b0, 1'b0, 8'h33, 1'b0, 1'b0};
    tbl[8]  = '{3'd6, 8'h3C, 8'h00, 1'b1, 1'b1, 8'h3C, 1'b0, 1'b0};
    tbl[9]  = '{3'd7, 8'h01, 8'h00, 1'b0, 1'b0, 8'h3C, 1'b0, 1'b0};
    tbl[10] = '{3'd0, 8'h10, 8'h00, 1'b1, 1'b1, 8'h11, 1'b0, 1'b0};

    // reset state
    @(posedge clk);
    #1;
    check("rst_in_ready", 32'(bus.in_ready), 32'd1);
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_y", 32'(bus.y), 32'd0);
    check("rst_y_zero", 32'(bus.y_zero), 32'd1);
    check("rst_y_ones", 32'(bus.y_ones), 32'd0);
    check("rst_state", 32'(dbg_state), 32'(IDLE));
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // directed table, out_ready held high
    for (int i = 0; i < 11; i++) begin
      bus.op = tbl[i].op;
      bus.a = tbl[i].a;
      bus.b = tbl[i].b;
      bus.in_last = tbl[i].last;
      bus.in_valid = 1'b1;
      @(posedge clk);
      #1;
      check($sformatf("vec%0d_valid", i), 32'(bus.out_valid), 32'(tbl[i].exp_v));
      check($sformatf("vec%0d_y", i), 32'(bus.y), 32'(tbl[i].exp_y));
      check($sformatf("vec%0d_y_zero", i), 32'(bus.y_zero), 32'(tbl[i].exp_z));
      check($sformatf("vec%0d_y_ones", i), 32'(bus.y_ones), 32'(tbl[i].exp_o));
    end
    bus.in_valid = 1'b0;
    @(posedge clk);
    #1;
    check("drain_valid", 32'(bus.out_valid), 32'd0);

    // backpressure hold, then back-to-back delivery
    dir_or = 1'b0;
    bus.op = 3'd0; bus.a = 8'hFF; bus.b = 8'hFF; bus.in_last = 1'b0; bus.in_valid = 1'b1;
    @(posedge clk);
    #1;
    check("bp_valid", 32'(bus.out_valid), 32'd1);
    check("bp_y", 32'(bus.y), 32'hFF);
    check("bp_y_ones", 32'(bus.y_ones), 32'd1);
    bus.op = 3'd1; bus.a = 8'h01; bus.b = 8'h02;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk);
      #1;
      check("bp_in_ready", 32'(bus.in_ready), 32'd0);
      check("bp_hold_y", 32'(bus.y), 32'hFF);
      check("bp_hold_valid", 32'(bus.out_valid), 32'd1);
    end
    dir_or = 1'b1;
    @(posedge clk);
    #1;
    check("b2b_valid", 32'(bus.out_valid), 32'd1);
    check("b2b_y", 32'(bus.y), 32'h03);
    check("b2b_y_ones", 32'(bus.y_ones), 32'd0);
    bus.in_valid = 1'b0;
    @(posedge clk);
    #1;
    check("b2b_drain", 32'(bus.out_valid), 32'd0);

    // reset in the middle of an ACC_OR burst
    bus.op = 3'd7; bus.a = 8'h01; bus.in_last = 1'b0; bus.in_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.a = 8'h02;
    @(posedge clk);
    #1;
    check("mid_state_acc", 32'(dbg_state), 32'(ACC));
    bus.in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    check("mrst_valid", 32'(bus.out_valid), 32'd0);
    check("mrst_y", 32'(bus.y), 32'd0);
    check("mrst_y_zero", 32'(bus.y_zero), 32'd1);
    check("mrst_in_ready", 32'(bus.in_ready), 32'd1);
    check("mrst_state", 32'(dbg_state), 32'(IDLE));
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    bus.op = 3'd7; bus.a = 8'h00; bus.in_last = 1'b1; bus.in_valid = 1'b1;
    @(posedge clk);
    #1;
    check("single_valid", 32'(bus.out_valid), 32'd1);
    check("single_y", 32'(bus.y), 32'd0);
    check("single_y_zero", 32'(bus.y_zero), 32'd1);
    check("single_state", 32'(dbg_state), 32'(IDLE));
    bus.in_valid = 1'b0;
    @(posedge clk);
    #1;

`ifdef LOGIC_UNIT_STATS_EN
    rst_n = 1'b0;
    #1;
    check("cnt_rst", 32'(op_count), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 7; i++) begin
      bus.op = (i < 3) ? OP_W'(i) : 3'd6;
      bus.a = 8'($urandom);
      bus.b = 8'($urandom);
      bus.in_last = (i == 6);
      bus.in_valid = 1'b1;
      @(posedge clk);
      #1;
    end
    bus.in_valid = 1'b0;
    @(posedge clk);
    #1;
    check("cnt_four", 32'(op_count), 32'd4);
`endif

    // randomized run against the reference model
    @(posedge clk);
    #1;
    sb_en = 1'b1;
    rnd_ready = 1'b1;
    for (int n = 0; n < 300; n++) begin
      if ($urandom_range(0, 4) == 0) begin
        @(posedge clk);
        #1;
      end
      send($urandom_range(0, 7), W'($urandom), W'($urandom), ($urandom_range(0, 2) == 0));
    end
    send(6, W'($urandom), W'($urandom), 1'b1);
    rnd_ready = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    check("rand_drain", 32'(exp_q.size()), 32'd0);
    sb_en = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/logic_unit_acc.md
# logic_unit_acc

Parametrised, registered bitwise logic unit with valid/ready handshaking and a multi-beat reduction mode. It generalises the two-input AND gate to any WIDTH, six selectable bitwise functions, and AND/OR accumulation across bursts of operands. It sits between an operand source and a result consumer in the lab datapath, and serves as the reusable logic stage for later ALU work.

## Interface
- WIDTH, 8, operand and result width in bits (≥1)
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  operand beat valid
- in_ready  output  1  unit can accept a beat
- in_last  input  1  final beat of an accumulate burst; ignored for ops 0–5
- op  input  3  function: 0 AND, 1 OR, 2 XOR, 3 NAND, 4 NOR, 5 XNOR, 6 ACC_AND, 7 ACC_OR
- a  input  WIDTH  operand A
- b  input  WIDTH  operand B; ignored for ops 6–7
- out_valid  output  1  result valid
- out_ready  input  1  consumer accepts result
- y  output  WIDTH  result
- y_zero  output  1  y == 0, registered with y
- y_ones  output  1  y == all ones, registered with y
- op_count  output  16  completed results; present only with LOGIC_UNIT_STATS_EN

## Operation
- Beat accepted when in_valid && in_ready. Result delivered when out_valid && out_ready.
- in_ready = !out_valid || out_ready, in every state.
- FSM states: IDLE, ACC.
- IDLE, accepted beat, op 0–5: y ← f(a,b), out_valid ← 1. State stays IDLE.
- IDLE, accepted beat, op 6/7, in_last=0: acc ← a, op latched. Go to ACC.
- IDLE, accepted beat, op 6/7, in_last=1: single-beat burst. y ← a, out_valid ← 1. State stays IDLE.
- ACC, accepted beat: acc ← acc AND a (or acc OR a, per latched op). The op input is ignored for the rest of the burst.
- ACC, accepted beat with in_last=1: y ← combined value, out_valid ← 1, return to IDLE.
- Non-final ACC beats do not touch y or out_valid. A held result stays stable while beats accumulate.
- out_valid clears on delivery unless a new result is written in the same cycle, in which case it stays 1 with the new y.
- y, y_zero and y_ones change only when a result is written.

## Timing
- Reset values: in_ready 1, out_valid 0, y 0, y_zero 1, y_ones 0, op_count 0. acc is cleared and the state returns to IDLE.
- Latency: out_valid is asserted the cycle after the accepting edge of a bitwise beat, or of a burst's last beat.
- Throughput: one beat per cycle while out_ready=1.
- Backpressure: with out_valid=1 and out_ready=0, in_ready=0 and no beat is accepted. This applies in ACC as well.
- Reset mid-burst drops the partial accumulation. No result is produced.
- WIDTH=1 must work; y_zero and y_ones are then complements.

## Configuration
- LOGIC_UNIT_STATS_EN defined:
  - op_count port exists.
  - op_count increments on each result write (not on delivery).
  - It saturates at 16'hFFFF.
  - Reset value is 0.
- Not defined: no port and no counter logic. All other behaviour is identical.

## Structure
- Package logic_unit_pkg holds:
  - enum logic_op_e with values 0–7 as above
  - enum state_e with IDLE and ACC
  - localparam OP_W = 3
- Sub-module logic_op_core: purely combinational. Takes op, a and b; returns f(a,b) for ops 0–5. Instantiated once.
- Accumulator, FSM, output register and stats counter live in logic_unit_acc.

## Test plan
- WIDTH=8, out_ready=1. Beats a=8'hF0, b=8'h3C with ops 0–5 in sequence. Expected y: 30, FC, CC, CF, 03, 33, each one cycle after its beat. y_zero=0 and y_ones=0 throughout.
- ACC_AND burst a = FF, 7E, 3C (last). Exactly one result, y=8'h3C. out_valid stays 0 during the first two beats.
- ACC_OR burst a = 01, 10 (last), with op driven to 0 on the second beat. Expected y=8'h11, because the latched op wins.
- Hold out_ready=0 after AND(FF,FF). Expected: y=FF, y_ones=1, in_ready=0 for 5 cycles, y stable. Then out_ready=1 with a new beat on the same cycle: back-to-back delivery, out_valid stays 1.
- Assert rst_n low after the 2nd beat of an ACC_OR burst. Expected: outputs return to reset values immediately. A new single-beat ACC_OR with a=8'h00, in_last=1 gives y=0 and y_zero=1.
- With LOGIC_UNIT_STATS_EN, drive 3 bitwise beats plus one 4-beat burst. Expected op_count=4.
